// File: rtl/freq_meter_pkg.sv
// Shared defaults and width helpers for the frequency meter.
// The optional glitch filter is enabled with FREQ_METER_GLITCH_FILT_EN.
package freq_meter_pkg;

    localparam int DEF_GATE_CYCLES = 50_000_000;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_AVG_LOG2    = 3;
    localparam int DEF_FILT_CYCLES = 4;

    // Bits needed for a counter that runs 0..n-1.
    function automatic int cnt_w_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Running sum of 2**avg_log2 values of cnt_w bits cannot overflow this width.
    function automatic int sum_w(input int cnt_w, input int avg_log2);
        return cnt_w + avg_log2;
    endfunction

endpackage

// File: rtl/freq_meter_edge_det.sv
// Synchroniser, optional glitch filter and rising-edge pulse for the meter input.
// FREQ_METER_GLITCH_FILT_EN inserts a FILT_CYCLES stability filter after the synchroniser.
module freq_edge_det
    import freq_meter_pkg::*;
#(
    parameter int FILT_CYCLES = DEF_FILT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic s1_q, s2_q, prev_q, lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= sig_i;
            s2_q   <= s1_q;
            prev_q <= lvl;
        end
    end

`ifdef FREQ_METER_GLITCH_FILT_EN
    localparam int FW = cnt_w_for(FILT_CYCLES);
    localparam logic [FW-1:0] STAB_LAST = FW'(FILT_CYCLES - 1);

    logic [FW-1:0] stab_q;
    logic          filt_q;

    // Level follows s2 only after it has disagreed for FILT_CYCLES samples in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_q <= '0;
            filt_q <= 1'b0;
        end else if (s2_q == filt_q) begin
            stab_q <= '0;
        end else if (stab_q == STAB_LAST) begin
            stab_q <= '0;
            filt_q <= s2_q;
        end else begin
            stab_q <= stab_q + 1'b1;
        end
    end

    assign lvl = filt_q;
`else
    logic unused_filt;
    assign unused_filt = ^FILT_CYCLES;
    assign lvl = s2_q;
`endif

    assign rise_o = lvl & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated rising-edge frequency meter with saturating count and 2**AVG_LOG2 moving average.
// Define FREQ_METER_GLITCH_FILT_EN to enable the input glitch filter.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int AVG_LOG2    = DEF_AVG_LOG2,
    parameter int FILT_CYCLES = DEF_FILT_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_raw,
    output logic [CNT_W-1:0] freq_avg,
    output logic             meas_valid,
    output logic             avg_full,
    output logic             ovf
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int GW    = cnt_w_for(GATE_CYCLES);
    localparam int SW    = sum_w(CNT_W, AVG_LOG2);
    localparam int FLW   = AVG_LOG2 + 1;
    localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [FLW-1:0] FILL_MAX  = FLW'(DEPTH);

    logic                rise;
    logic                win_last;
    logic [GW-1:0]       gate_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                win_ovf_q, win_ovf_d;
    logic [CNT_W-1:0]    ring_q [DEPTH];
    logic [SW-1:0]       sum_q, sum_d;
    logic [AVG_LOG2-1:0] wr_ptr_q;
    logic [FLW-1:0]      fill_q;
    logic [CNT_W-1:0]    raw_q, avg_q;
    logic                vld_q, ovf_q;

    freq_edge_det #(.FILT_CYCLES(FILT_CYCLES)) u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (sig_in),
        .rise_o (rise)
    );

    // cnt_d/win_ovf_d include an edge on the current cycle, so the terminal cycle's
    // edge lands in the closing window.
    always_comb begin
        win_last  = (gate_q == GATE_LAST);
        cnt_d     = (rise && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        win_ovf_d = win_ovf_q | (rise & (&cnt_q));
        sum_d     = sum_q + SW'(cnt_d) - SW'(ring_q[wr_ptr_q]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q    <= '0;
            cnt_q     <= '0;
            win_ovf_q <= 1'b0;
            sum_q     <= '0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            raw_q     <= '0;
            avg_q     <= '0;
            vld_q     <= 1'b0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
        end else if (clr) begin
            gate_q    <= '0;
            cnt_q     <= '0;
            win_ovf_q <= 1'b0;
            sum_q     <= '0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            raw_q     <= '0;
            avg_q     <= '0;
            vld_q     <= 1'b0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
        end else begin
            vld_q <= 1'b0;
            if (en) begin
                if (win_last) begin
                    gate_q           <= '0;
                    cnt_q            <= '0;
                    win_ovf_q        <= 1'b0;
                    raw_q            <= cnt_d;
                    ovf_q            <= win_ovf_d;
                    ring_q[wr_ptr_q] <= cnt_d;
                    sum_q            <= sum_d;
                    avg_q            <= sum_d[SW-1:AVG_LOG2];
                    wr_ptr_q         <= wr_ptr_q + 1'b1;
                    vld_q            <= 1'b1;
                    if (fill_q != FILL_MAX) fill_q <= fill_q + 1'b1;
                end else begin
                    gate_q    <= gate_q + 1'b1;
                    cnt_q     <= cnt_d;
                    win_ovf_q <= win_ovf_d;
                end
            end
        end
    end

    assign freq_raw   = raw_q;
    assign freq_avg   = avg_q;
    assign meas_valid = vld_q;
    assign avg_full   = fill_q[AVG_LOG2];
    assign ovf        = ovf_q;

endmodule
